// File: rtl/fma_arbiter.sv
// Round-robin arbiter sharing one combinational FMA between two requesters, with LAT result stages.
// Optional macro FMA_ARBITER_PERF_EN adds saturating issue/conflict counters.
module fma_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_c,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_c,
  output logic [31:0] fma_a,
  output logic [31:0] fma_b,
  output logic [31:0] fma_c,
  input  logic [31:0] fma_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        busy
`ifdef FMA_ARBITER_PERF_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] conflict_cnt
`endif
);

  logic        stall;
  logic        gnt_any;
  logic        gnt_id;
  logic        ptr_q, ptr_d;
  logic        s0_vld_q, s0_vld_d;
  logic        s0_id_q, s0_id_d;
  logic [31:0] s0_a_q, s0_a_d;
  logic [31:0] s0_b_q, s0_b_d;
  logic [31:0] s0_c_q, s0_c_d;
  logic [LAT:1] vld_q;
  logic [LAT:1] id_q;
  logic [31:0]  res_q [1:LAT];

  assign stall      = resp_valid & ~resp_ready;
  assign resp_valid = vld_q[LAT];
  assign resp_id    = id_q[LAT];
  assign resp_data  = res_q[LAT];
  assign busy       = s0_vld_q | (|vld_q);
  assign fma_a      = s0_a_q;
  assign fma_b      = s0_b_q;
  assign fma_c      = s0_c_q;

  // rst_n gates the grant so ready stays low while reset is held
  always_comb begin
    gnt_any    = rst_n & ~stall & (req0_valid | req1_valid);
    gnt_id     = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    req0_ready = gnt_any & ~gnt_id;
    req1_ready = gnt_any & gnt_id;
    ptr_d      = gnt_any ? ~gnt_id : ptr_q;
    s0_vld_d   = s0_vld_q;
    s0_id_d    = s0_id_q;
    s0_a_d     = s0_a_q;
    s0_b_d     = s0_b_q;
    s0_c_d     = s0_c_q;
    if (!stall) begin
      s0_vld_d = gnt_any;
      if (gnt_any) begin
        s0_id_d = gnt_id;
        s0_a_d  = gnt_id ? req1_a : req0_a;
        s0_b_d  = gnt_id ? req1_b : req0_b;
        s0_c_d  = gnt_id ? req1_c : req0_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= 1'b0;
      s0_vld_q <= 1'b0;
      s0_id_q  <= 1'b0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      s0_c_q   <= '0;
      vld_q    <= '0;
      id_q     <= '0;
      for (int k = 1; k <= LAT; k++) res_q[k] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      s0_vld_q <= s0_vld_d;
      s0_id_q  <= s0_id_d;
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      s0_c_q   <= s0_c_d;
      if (!stall) begin
        vld_q[1] <= s0_vld_q;
        id_q[1]  <= s0_id_q;
        res_q[1] <= fma_result;
        for (int k = 2; k <= LAT; k++) begin
          vld_q[k] <= vld_q[k-1];
          id_q[k]  <= id_q[k-1];
          res_q[k] <= res_q[k-1];
        end
      end
    end
  end

`ifdef FMA_ARBITER_PERF_EN
  logic [15:0] issue_cnt_q;
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (gnt_any && issue_cnt_q != 16'hFFFF)
        issue_cnt_q <= issue_cnt_q + 16'd1;
      if (req0_valid && req1_valid && !stall && conflict_cnt_q != 16'hFFFF)
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign issue_cnt    = issue_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fma_arbiter.sv
// Self-checking bench for fma_arbiter: scoreboard of expected results plus per-scenario tasks.
// Counter checks are built when FMA_ARBITER_PERF_EN is defined.
module tb_fma_arbiter;
  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req0_c;
  logic [31:0] req1_a, req1_b, req1_c;
  logic [31:0] fma_a, fma_b, fma_c;
  logic [31:0] fma_result;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        busy;
`ifdef FMA_ARBITER_PERF_EN
  logic [15:0] issue_cnt, conflict_cnt;
`endif

  fma_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy)
`ifdef FMA_ARBITER_PERF_EN
    , .issue_cnt(issue_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision model for normal operands, evaluated in double precision.
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fma_model(input logic [31:0] a, b, c);
    return r2sp(sp2r(a) * sp2r(b) + sp2r(c));
  endfunction

  function automatic logic [31:0] fl(input int n);
    return r2sp(real'(n));
  endfunction

  always_comb fma_result = fma_model(fma_a, fma_b, fma_c);

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_mon;
  logic        grant_log[$];
  logic        resp_log[$];
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_id;

  // Scoreboard: push on accept, pop on response; also checks hold during stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== prev_data || resp_id !== prev_id) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b data=%h id=%b, required valid=1 data=%h id=%b",
                   resp_valid, resp_data, resp_id, prev_data, prev_id);
        end
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back({1'b0, fma_model(req0_a, req0_b, req0_c)});
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back({1'b1, fma_model(req1_a, req1_b, req1_c)});
        grant_log.push_back(1'b1);
      end
      if (resp_valid && resp_ready) begin
        resp_log.push_back(resp_id);
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resp: got data=%h id=%b, required no response", resp_data, resp_id);
        end else begin
          e_mon = sb_q.pop_front();
          if (resp_data !== e_mon.data || resp_id !== e_mon.id) begin
            n_err++;
            $display("FAIL resp_order: got data=%h id=%b, required data=%h id=%b",
                     resp_data, resp_id, e_mon.data, e_mon.id);
          end
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
      prev_id    = resp_id;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    if (k == 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=%b pending=%0d, required busy=0 pending=0", busy, sb_q.size());
    end
    cyc();
  endtask

  task automatic set_ops(input int s);
    req0_a = fl(s + 1); req0_b = fl(s + 2); req0_c = fl(s + 3);
    req1_a = fl(s + 4); req1_b = fl(s + 5); req1_c = fl(s + 6);
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    req0_a = fl(4); req0_b = fl(5); req0_c = fl(6);
    set_ops(7);
    req0_a = fl(4); req0_b = fl(5); req0_c = fl(6);
    @(negedge clk);
    n_cmp++;
    if ({resp_valid, busy, req0_ready, req1_ready, resp_id} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid/busy/rdy0/rdy1/id=%b, required 00000",
               {resp_valid, busy, req0_ready, req1_ready, resp_id});
    end
    n_cmp++;
    if (resp_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 00000000", resp_data);
    end
    n_cmp++;
    if ({fma_a, fma_b, fma_c} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_fma_ops: got %h %h %h, required zeros", fma_a, fma_b, fma_c);
    end
    cyc();
    rst_n = 1'b1;
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL first_clock_accept: got req0_ready=%b, required 1", req0_ready);
    end
    cyc();
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    cyc();
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_c = 32'h3F800000;
    req0_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %b, required 1", req0_ready);
    end
    for (int i = 1; i <= LAT; i++) begin
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL single_early: cycle %0d got resp_valid=%b, required 0", i, resp_valid);
      end
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h40E00000 || resp_id !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: got valid=%b data=%h id=%b, required valid=1 data=40e00000 id=0",
               resp_valid, resp_data, resp_id);
    end
    wait_idle();
  endtask

  task automatic test_contention();
    logic [3:0] ids;
    resp_ready = 1'b1;
    do_reset();
    resp_log.delete();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      set_ops(10 + i);
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL contention_grant: cycle %0d got rdy1/rdy0=%b%b, required %s",
                 i, req1_ready, req0_ready, (i % 2 == 1) ? "10" : "01");
      end
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    ids = 4'hF;
    if (resp_log.size() == 4) ids = {resp_log[0], resp_log[1], resp_log[2], resp_log[3]};
    n_cmp++;
    if (resp_log.size() != 4 || ids !== 4'b0101) begin
      n_err++;
      $display("FAIL contention_ids: got count=%0d ids=%b, required count=4 ids=0101", resp_log.size(), ids);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_data;
    logic        held_id;
    int          k;
    grant_log.delete();
    resp_log.delete();
    resp_ready = 1'b0;
    for (k = 0; k < 10; k++) begin
      cyc();
      set_ops(20 + k);
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      if (resp_valid) break;
    end
    if (k == 10) begin
      n_cmp++;
      n_err++;
      $display("FAIL bp_fill_timeout: got resp_valid=0, required 1 within 10 cycles");
    end
    held_data = resp_data;
    held_id   = resp_id;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      n_cmp++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready: stall cycle %0d got rdy0=%b rdy1=%b, required 0 0", j, req0_ready, req1_ready);
      end
      n_cmp++;
      if (resp_data !== held_data || resp_id !== held_id) begin
        n_err++;
        $display("FAIL bp_hold: got data=%h id=%b, required data=%h id=%b", resp_data, resp_id, held_data, held_id);
      end
    end
    cyc();
    resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (grant_log.size() != 3 || resp_log.size() != 3) begin
      n_err++;
      $display("FAIL bp_count: got accepted=%0d responded=%0d, required 3 3", grant_log.size(), resp_log.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      set_ops(40 + i);
      req0_valid = 1'b1;
      @(negedge clk);
    end
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_setup: got busy=%b resp_valid=%b, required 1 1", busy, resp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got resp_valid=%b busy=%b, required 0 0", resp_valid, busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    resp_log.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
      cyc();
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_stale: got %0d responses, required 0", seen);
    end
    set_ops(50);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pointer: got rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_throughput();
    int first, last, cnt, bad_id, nacc;
    resp_ready = 1'b1;
    first = -1; last = -1; cnt = 0; bad_id = 0; nacc = 0;
    req0_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      set_ops(60 + c);
      req1_valid = (c < 10);
      @(negedge clk);
      if (req1_valid && req1_ready) nacc++;
      if (resp_valid) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
        if (resp_id !== 1'b1) bad_id++;
      end
    end
    req1_valid = 1'b0;
    n_cmp++;
    if (nacc != 10) begin
      n_err++;
      $display("FAIL tput_accepts: got %0d, required 10", nacc);
    end
    n_cmp++;
    if (cnt != 10 || first != LAT + 1 || last != LAT + 10) begin
      n_err++;
      $display("FAIL tput_resp: got count=%0d first=%0d last=%0d, required 10 %0d %0d",
               cnt, first, last, LAT + 1, LAT + 10);
    end
    n_cmp++;
    if (bad_id != 0) begin
      n_err++;
      $display("FAIL tput_id: got %0d responses with id!=1, required 0", bad_id);
    end
    wait_idle();
  endtask

`ifdef FMA_ARBITER_PERF_EN
  task automatic test_perf();
    resp_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      set_ops(80 + i);
      req0_valid = 1'b1;
      req1_valid = (i < 3);
      @(negedge clk);
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (issue_cnt !== 16'd6) begin
      n_err++;
      $display("FAIL perf_issue: got %0d, required 6", issue_cnt);
    end
    n_cmp++;
    if (conflict_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL perf_conflict: got %0d, required 3", conflict_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    set_ops(0);
    #1 rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_throughput();
`ifdef FMA_ARBITER_PERF_EN
    test_perf();
`endif
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
